// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// muldiv_pkg : shared types, constants and helpers for the RV32M mul/div unit
// Revision   : 1.0
// ============================================================================
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest value the helpers operate on; the full 2*XLEN product must fit.
  localparam int MAX_W = 64;

  localparam logic [MAX_W-1:0] DIV_BY_ZERO_Q = '1;

  // Two's-complement negation when neg is set, pass-through otherwise.
  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? (~v + MAX_W'(1)) : v;
  endfunction

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit : iterative RV32M multiply/divide, one result bit per clock
// Revision    : 1.0
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we_out
);

  localparam int              CW      = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              r_state;
  op_t                 r_op;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_b;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [CW-1:0]       r_count;

  op_t                 w_op;
  logic                w_sa, w_sb, w_neg_a, w_neg_b;
  logic [XLEN-1:0]     w_mag_a, w_mag_b;
  logic                w_div0, w_ovf;
  logic [XLEN-1:0]     w_special_res;
  logic [XLEN:0]       w_diff;
  logic [XLEN:0]       w_sum;
  logic [2*XLEN-1:0]   w_acc_next;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quot, w_rem;
  logic [XLEN-1:0]     w_final;

  // Operand conditioning at accept time.
  always_comb begin
    w_op    = op_t'(op);
    w_sa    = (w_op == OP_MULH) || (w_op == OP_MULHSU) || (w_op == OP_DIV) || (w_op == OP_REM);
    w_sb    = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
    w_neg_a = w_sa && rs1_val[XLEN-1];
    w_neg_b = w_sb && rs2_val[XLEN-1];
    w_mag_a = XLEN'(cond_neg(MAX_W'(rs1_val), w_neg_a));
    w_mag_b = XLEN'(cond_neg(MAX_W'(rs2_val), w_neg_b));
    w_div0  = op[2] && (rs2_val == '0);
    w_ovf   = ((w_op == OP_DIV) || (w_op == OP_REM)) && (rs1_val == MIN_NEG) && (rs2_val == '1);
    if (w_div0) begin
      w_special_res = op[1] ? rs1_val : XLEN'(DIV_BY_ZERO_Q);
    end else begin
      w_special_res = op[1] ? '0 : MIN_NEG;
    end
  end

  // Shared iteration step: r_acc holds {partial/remainder, multiplier/quotient}.
  always_comb begin
    w_diff = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_b};
    w_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    if (r_op[2]) begin
      if (w_diff[XLEN]) begin
        w_acc_next = {r_acc[2*XLEN-2:0], 1'b0};
      end else begin
        w_acc_next = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      end
    end else begin
      w_acc_next = {w_sum, r_acc[XLEN-1:1]};
    end
  end

  // Sign fixup applied on the final step so result is ready in DONE.
  always_comb begin
    w_prod = (2*XLEN)'(cond_neg(MAX_W'(w_acc_next), r_neg_q));
    w_quot = XLEN'(cond_neg(MAX_W'(w_acc_next[XLEN-1:0]), r_neg_q));
    w_rem  = XLEN'(cond_neg(MAX_W'(w_acc_next[2*XLEN-1:XLEN]), r_neg_r));
    case (r_op)
      OP_MUL:                         w_final = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   w_final = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:                w_final = w_quot;
      default:                        w_final = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= OP_MUL;
      r_acc   <= '0;
      r_b     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_count <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      we_out  <= 1'b0;
      result  <= '0;
      rd_out  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          done   <= 1'b0;
          we_out <= 1'b0;
          if (start) begin
            r_op    <= w_op;
            rd_out  <= rd_addr;
            busy    <= 1'b1;
            r_count <= '0;
            if (w_div0 || w_ovf) begin
              result  <= w_special_res;
              done    <= 1'b1;
              we_out  <= (rd_addr != 5'd0);
              r_state <= DONE;
            end else begin
              r_acc   <= {{XLEN{1'b0}}, w_mag_a};
              r_b     <= w_mag_b;
              r_neg_q <= w_neg_a ^ w_neg_b;
              r_neg_r <= w_neg_a;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_acc   <= w_acc_next;
          r_count <= r_count + 1'b1;
          if (r_count == LAST) begin
            result  <= w_final;
            done    <= 1'b1;
            we_out  <= (rd_out != 5'd0);
            r_state <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          we_out  <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : muldiv_unit
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_muldiv_unit : table, hand-written and randomized checks of muldiv_unit
// Revision       : 1.0
// ============================================================================
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd_addr;
  logic        busy, done, we_out;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_vec  = 0;
  int n_fail = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_addr (rd_addr),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .rd_out  (rd_out),
    .we_out  (we_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference built from the RV32M arithmetic rules using 64-bit integers.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] t;
    logic        ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin t = {32'd0, a} * {32'd0, b}; return t[31:0]; end
      3'd1: begin t = 64'(sa * sb); return t[63:32]; end
      3'd2: begin t = 64'(sa * longint'({32'd0, b})); return t[63:32]; end
      3'd3: begin t = {32'd0, a} * {32'd0, b}; return t[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        t = 64'(sa / sb); return t[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        t = 64'(sa % sb); return t[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && b == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one operation; optionally inject a second start, a reset, or a start in DONE.
  task automatic do_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res,
                       input int exp_lat, input int restart_at, input int rst_at, input bit sid);
    int cyc, busy_low, stray;
    bit got;
    @(negedge clk);
    op = o; rs1_val = a; rs2_val = b; rd_addr = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); rs1_val = $urandom; rs2_val = $urandom; rd_addr = 5'($urandom);
    cyc = 1; got = 1'b0; busy_low = 0;
    while (!got && cyc <= 40) begin
      if (!busy) busy_low++;
      if (done) begin
        got = 1'b1;
      end else begin
        if (cyc == restart_at) begin
          start = 1'b1; op = 3'd3; rs1_val = 32'hFFFF_FFFF; rs2_val = 32'hFFFF_FFFF; rd_addr = 5'd9;
        end
        if (cyc == rst_at) rst = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (rst) begin
          rst = 1'b0;
          check({nm, " rst-outputs"}, {24'd0, busy, done, we_out, rd_out, result}, 64'd0);
          stray = 0;
          repeat (3) begin
            @(posedge clk); #1;
            if (we_out || done || busy) stray++;
          end
          check({nm, " rst-quiet"}, 64'(stray), 64'd0);
          return;
        end
        cyc++;
      end
    end
    if (!got) begin
      check({nm, " timeout"}, 64'd1, 64'd0);
      return;
    end
    check({nm, " result"},  64'(result), 64'(exp_res));
    check({nm, " latency"}, 64'(cyc), 64'(exp_lat));
    check({nm, " rd_out"},  64'(rd_out), 64'(rd));
    check({nm, " we_out"},  64'(we_out), 64'(rd != 5'd0));
    check({nm, " busy"},    64'(busy_low), 64'd0);
    if (sid) begin
      start = 1'b1; op = 3'd0; rs1_val = 32'd3; rs2_val = 32'd3; rd_addr = 5'd4;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check({nm, " after-done"}, {61'd0, busy, done, we_out}, 64'd0);
    check({nm, " held"}, 64'(result), 64'(exp_res));
  endtask

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33};
    tbl[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 33};
    tbl[2]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd2,  32'h4000_0000, 33};
    tbl[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 33};
    tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFD, 33};
    tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFF, 33};
    tbl[6]  = '{3'd5, 32'd100,        32'd7,         5'd8,  32'd14,        33};
    tbl[7]  = '{3'd7, 32'd100,        32'd7,         5'd31, 32'd2,         33};
    tbl[8]  = '{3'd5, 32'd5,          32'd0,         5'd10, 32'hFFFF_FFFF, 1};
    tbl[9]  = '{3'd6, 32'd5,          32'd0,         5'd11, 32'd5,         1};
    tbl[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1};
    tbl[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'd0,         1};
    tbl[12] = '{3'd0, 32'd3,          32'd4,         5'd0,  32'd12,        33};

    rst = 1'b1; start = 1'b0; op = '0; rs1_val = '0; rs2_val = '0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", {24'd0, busy, done, we_out, rd_out, result}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      do_op($sformatf("tbl%0d", i), tbl[i].o, tbl[i].a, tbl[i].b, tbl[i].rd,
            tbl[i].exp, tbl[i].lat, 0, 0, 1'b0);
    end

    // Second start mid-MUL must not disturb the latched operands.
    do_op("mul-restart", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33, 10, 0, 1'b0);
    // Reset in the middle of a DIV, then a clean operation right after.
    do_op("div-rst", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'd0, 33, 0, 15, 1'b0);
    do_op("post-rst", 3'd5, 32'd100, 32'd7, 5'd3, 32'd14, 33, 0, 0, 1'b0);
    // Start arriving in the DONE cycle is ignored.
    do_op("start-in-done", 3'd5, 32'd5, 32'd0, 5'd4, 32'hFFFF_FFFF, 1, 0, 0, 1'b1);

    for (int i = 0; i < 150; i++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      int          mode;
      o    = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 7);
      a    = $urandom;
      b    = $urandom;
      case (mode)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
        3: a = -($urandom_range(1, 1000));
        default: ;
      endcase
      do_op($sformatf("rnd%0d op%0d", i, o), o, a, b, 5'($urandom), model(o, a, b),
            model_lat(o, a, b), 0, 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_muldiv_unit
`default_nettype wire
